step_ramp_ctrl: RTL

Motion-profile controller that sequences the Dynamo pulse generator for one move. It drives the generator's half-period divider value and its disable input, and counts the generator's output steps. It produces a trapezoidal (or triangular) profile: accelerate from div_start to div_min, cruise, then decelerate symmetrically so the last step runs at div_start. It sits between the host or command logic and the pulse generator instance.

---
 rtl/step_ramp_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/step_ramp_ctrl.sv
// Trapezoidal/triangular step-rate profile sequencer for a half-period pulse generator.
// Ramps the divider down to dmin, cruises, then ramps back so the last step runs at div_start.
module step_ramp_ctrl #(
  parameter int WIDTH1 = 20,
  parameter int STEP_W = 24
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [STEP_W-1:0] target_steps,
  input  logic [WIDTH1-1:0] div_start,
  input  logic [WIDTH1-1:0] div_min,
  input  logic [WIDTH1-1:0] div_step,
  input  logic              pulse_in,
  output logic [WIDTH1-1:0] counter_out,
  output logic              pulse_dis,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] step_cnt
);

  typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, TAIL, DONE} state_t;

  state_t            state;
  logic              pulse_q, abort_pend;
  logic [STEP_W-1:0] tgt, acc_steps, step_nxt, remain;
  logic [WIDTH1-1:0] dstart, dmin, dstep, up_div;
  logic [WIDTH1:0]   up_sum, acc_floor;
  logic              rise, fall, ramp_up_end;

  assign rise     = pulse_in & ~pulse_q;
  assign fall     = ~pulse_in & pulse_q;
  assign step_nxt = step_cnt + 1'b1;
  assign remain   = tgt - step_nxt;

  // One extra bit keeps the ramp arithmetic free of wrap-around at both ends.
  assign up_sum      = {1'b0, counter_out} + {1'b0, dstep};
  assign up_div      = (up_sum > {1'b0, dstart}) ? dstart : up_sum[WIDTH1-1:0];
  assign acc_floor   = {1'b0, dmin} + {1'b0, dstep};
  assign ramp_up_end = ({1'b0, counter_out} <= acc_floor);

  always_ff @(posedge clk_50m) begin
    if (!rst) begin
      state       <= IDLE;
      pulse_q     <= 1'b0;
      abort_pend  <= 1'b0;
      counter_out <= '1;
      pulse_dis   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      step_cnt    <= '0;
      acc_steps   <= '0;
      tgt         <= '0;
      dstart      <= '0;
      dmin        <= '0;
      dstep       <= '0;
    end else begin
      pulse_q <= pulse_in;
      done    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tgt         <= target_steps;
          dstart      <= div_start;
          dmin        <= (div_min < div_start) ? div_min : div_start;
          dstep       <= div_step;
          counter_out <= div_start;
          step_cnt    <= '0;
          acc_steps   <= '0;
          aborted     <= 1'b0;
          abort_pend  <= 1'b0;
          if (target_steps == '0) begin
            pulse_dis <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            pulse_dis <= 1'b0;
            busy      <= 1'b1;
            state     <= ACCEL;
          end
        end
        ACCEL, CRUISE, DECEL: begin
          // counter_out only moves on a rise, while the generator count is still 0 or 1.
          if (rise) begin
            step_cnt <= step_nxt;
            if (remain == '0) begin
              state <= TAIL;
            end else if (state == DECEL) begin
              if (abort_pend && counter_out == dstart) state <= TAIL;
              else counter_out <= up_div;
            end else if (abort_pend || remain <= acc_steps) begin
              counter_out <= up_div;
              state       <= DECEL;
            end else if (state == ACCEL) begin
              acc_steps <= acc_steps + 1'b1;
              if (ramp_up_end) begin
                counter_out <= dmin;
                state       <= CRUISE;
              end else begin
                counter_out <= counter_out - dstep;
              end
            end
          end
          if (abort) abort_pend <= 1'b1;
        end
        TAIL: if (fall) begin
          pulse_dis <= 1'b1;
          busy      <= 1'b0;
          done      <= 1'b1;
          aborted   <= abort_pend;
          state     <= DONE;
        end
        DONE: begin
          abort_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
